// File: rtl/stream_arb_mux.sv
// N_CH-to-1 valid/ready stream arbiter and mux with a single registered output slot.
// Arbitration is round-robin, fixed priority, forced select, or hold, chosen by mode.
module stream_arb_mux #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        ModeRr    = 2'b00,
        ModeFixed = 2'b01,
        ModeForce = 2'b10,
        ModeHold  = 2'b11
    } mode_e;

    logic [SEL_W-1:0] ptr;
    logic             can_load;
    logic             lo_any, hi_any;
    logic [SEL_W-1:0] lo_idx, hi_idx;
    logic             found;
    logic [SEL_W-1:0] gidx;
    logic [N_CH-1:0]  grant;
    logic [W-1:0]     mux_data;
    logic             xfer_in;
    logic [SEL_W-1:0] ptr_next;

    assign can_load = ~out_valid | out_ready;

    // Descending scan leaves the lowest valid index overall (lo) and the lowest
    // valid index at or above ptr (hi); round-robin prefers hi and wraps to lo.
    always_comb begin
        lo_any = 1'b0;
        hi_any = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        case (mode_e'(mode))
            ModeRr: begin
                found = hi_any | lo_any;
                gidx  = hi_any ? hi_idx : lo_idx;
            end
            ModeFixed: begin
                found = lo_any;
                gidx  = lo_idx;
            end
            ModeForce: begin
                // An out-of-range sel never matches any channel, so it grants nothing.
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (SEL_W'(i) == sel && in_valid[i]) begin
                        found = 1'b1;
                        gidx  = sel;
                    end
                end
            end
            default: begin
                found = 1'b0;
                gidx  = '0;
            end
        endcase
    end

    always_comb begin
        grant    = '0;
        mux_data = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            grant[i] = found && (gidx == SEL_W'(i));
            if (grant[i]) begin
                mux_data = in_data[i*W +: W];
            end
        end
    end

    assign in_ready = grant & {N_CH{can_load & ~rst}};
    assign xfer_in  = found & can_load & ~rst;
    assign ptr_next = (gidx == SEL_W'(N_CH - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer_in) begin
            // Load also covers the simultaneous drain-and-refill case with no bubble.
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_ch    <= gidx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
- REQ-001: Parameter N_CH, default 4, number of input channels; legal range 2..16.
- REQ-002: Parameter W, default 8, data width per channel; legal range 1..64.
- REQ-003: Parameter SEL_W, default 2, channel-index width; SHALL equal ceil(log2(N_CH)).
- REQ-004: Port list, clock and reset first:
  - clk  input  1  single clock; all state updates on the rising edge.
  - rst  input  1  asynchronous, active-high reset.
  - in_valid  input  N_CH  per-channel valid.
  - in_data  input  N_CH*W  packed data; channel i occupies bits [i*W+W-1 : i*W].
  - in_ready  output  N_CH  per-channel ready; combinational.
  - mode  input  2  00 round-robin, 01 fixed priority, 10 forced select, 11 hold.
  - sel  input  SEL_W  channel index used in forced-select mode.
  - out_valid  output  1  registered output valid.
  - out_data  output  W  registered output data.
  - out_ch  output  SEL_W  registered source-channel index of out_data.
  - out_ready  input  1  downstream ready.

Function
- REQ-005: A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a rising clk edge.
- REQ-006: A transfer on the output SHALL occur when out_valid and out_ready are both high at a rising clk edge.
- REQ-007: Output stage SHALL be a single register slot; can_load = ~out_valid | out_ready.
- REQ-008: Grant SHALL be one-hot or zero, computed combinationally from in_valid, mode, sel and ptr.
- REQ-009: in_ready[i] SHALL equal grant[i] & can_load; at most one in_ready bit high in any cycle.
- REQ-010: Round-robin (00): grant the first valid channel searching upward from ptr, wrapping N_CH-1 -> 0.
- REQ-011: Fixed priority (01): grant the lowest-indexed valid channel.
- REQ-012: Forced select (10): grant channel sel only if in_valid[sel]; sel >= N_CH SHALL grant nothing.
- REQ-013: Hold (11): grant nothing; the output register still drains normally.
- REQ-014: On an input transfer from channel g: out_data <= in_data[g], out_ch <= g, out_valid <= 1, all in the same edge; latency from input handshake to out_valid SHALL be 1 cycle.
- REQ-015: out_valid SHALL fall only when an output transfer occurs with no input transfer on the same edge.
- REQ-016: A simultaneous output transfer and input transfer SHALL replace the register contents, with no bubble, giving full throughput of one word per cycle.
- REQ-017: While out_valid=1 and out_ready=0, out_data and out_ch SHALL remain stable.
- REQ-018: ptr (SEL_W bits) SHALL update only on an input transfer, to (g+1) mod N_CH, in every mode.
- REQ-019: A mode or sel change SHALL affect the grant in the same cycle; it SHALL never corrupt a held output word.
- REQ-020: No valid input, or a zero grant, SHALL leave the output register unchanged except for a drain per REQ-015.

Reset
- REQ-021: While rst is high: out_valid=0, out_data=0, out_ch=0, ptr=0, asynchronously and independent of clk.
- REQ-022: in_ready SHALL be 0 while rst is high.
- REQ-023: A word held at reset assertion SHALL be discarded; the first post-reset round-robin grant SHALL search from channel 0.

Verification
- REQ-024: Round-robin mode, all four channels valid with data 0xA0..0xA3, out_ready=1 -> out_ch sequence 0,1,2,3,0; one word per cycle; first out_valid 1 cycle after the first handshake.
- REQ-025: Backpressure: out_ready=0 for 5 cycles while holding 0x55 from ch2 -> out_data=0x55, out_ch=2 stable; in_ready all 0; resumes on the next edge after out_ready=1.
- REQ-026: Fixed priority, ch1 and ch3 valid continuously -> only ch1 transfers; ch3 starves; in_ready[3]=0 throughout.
- REQ-027: Forced select sel=3, ch3 valid with 0x7E, ch0 valid -> out_data=0x7E, out_ch=3; sel=3 with ch3 idle -> no transfer.
- REQ-028: Assert rst mid-stream with out_valid=1 -> out_valid=0 immediately, before the next clk edge; after release, round-robin with all channels valid grants ch0 first.
- REQ-029: Wrap check: ptr=3 after a ch2 transfer, only ch0 and ch1 valid -> ch0 granted next (3 -> 0 wrap).
